// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter handshake bundle for the two-port UART TX arbiter.
// slave = arbiter side, master = requesters plus transmitter model.
interface uart_tx_arbiter_if;
   logic       req0_valid;
   logic       req1_valid;
   logic [7:0] req0_data;
   logic [7:0] req1_data;
   logic       req0_last;
   logic       req1_last;
   logic       req0_ready;
   logic       req1_ready;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [1:0] grant;
   logic       timeout_err;

   modport slave (
      input  req0_valid, req1_valid, req0_data, req1_data, req0_last, req1_last,
      input  tx_ready, tx_done,
      output req0_ready, req1_ready, tx_start, tx_data, grant, timeout_err
   );

   modport master (
      output req0_valid, req1_valid, req0_data, req1_data, req0_last, req1_last,
      output tx_ready, tx_done,
      input  req0_ready, req1_ready, tx_start, tx_data, grant, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter giving two byte-stream requesters packet-atomic access
// to a single UART transmitter, with an inter-packet gap and stall timeout.
module uart_tx_arbiter #(
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input logic              CLK100MHZ,
   input logic              reset,
   uart_tx_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = 17;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, GAP} state_t;

   // With no gap configured a finished packet goes straight back to arbitration.
   localparam state_t POST_PKT = (GAP_CYCLES == 0) ? IDLE : GAP;

   state_t           state_q;
   logic [1:0]       grant_q;
   logic             ptr_q;
   logic [7:0]       tx_data_q;
   logic             last_q;
   logic             tx_start_q;
   logic             timeout_err_q;
   logic [CNT_W-1:0] idle_cnt_q;
   logic [GAP_W-1:0] gap_cnt_q;

   logic       sel_valid;
   logic       sel_last;
   logic [7:0] sel_data;
   logic       accept;
   logic       pick_req1;

   // Mux the granted requester; ptr_q=1 means req1 wins a tie.
   always_comb begin
      sel_valid = bus.req0_valid;
      sel_last  = bus.req0_last;
      sel_data  = bus.req0_data;
      if (grant_q[1]) begin
         sel_valid = bus.req1_valid;
         sel_last  = bus.req1_last;
         sel_data  = bus.req1_data;
      end
      accept    = (state_q == LOAD) && sel_valid && bus.tx_ready;
      pick_req1 = bus.req1_valid && (!bus.req0_valid || ptr_q);
   end

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= 2'b00;
         ptr_q         <= 1'b0;
         tx_data_q     <= 8'h00;
         last_q        <= 1'b0;
         tx_start_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         idle_cnt_q    <= '0;
         gap_cnt_q     <= '0;
      end else begin
         tx_start_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req0_valid || bus.req1_valid) begin
                  grant_q    <= pick_req1 ? 2'b10 : 2'b01;
                  idle_cnt_q <= '0;
                  state_q    <= LOAD;
               end
            end
            LOAD: begin
               if (accept) begin
                  tx_data_q  <= sel_data;
                  last_q     <= sel_last;
                  idle_cnt_q <= '0;
                  tx_start_q <= 1'b1;
                  state_q    <= SEND;
               end else if (!sel_valid) begin
                  // Only a silent requester ages; a tx_ready stall does not.
                  if (idle_cnt_q == TIMEOUT_LAST) begin
                     timeout_err_q <= 1'b1;
                     grant_q       <= 2'b00;
                     ptr_q         <= grant_q[0];
                     idle_cnt_q    <= '0;
                     gap_cnt_q     <= '0;
                     state_q       <= POST_PKT;
                  end else begin
                     idle_cnt_q <= idle_cnt_q + CNT_W'(1);
                  end
               end
            end
            SEND: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (bus.tx_done) begin
                  if (last_q) begin
                     grant_q   <= 2'b00;
                     ptr_q     <= grant_q[0];
                     gap_cnt_q <= '0;
                     state_q   <= POST_PKT;
                  end else begin
                     state_q <= LOAD;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_q <= IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req0_ready  = accept && grant_q[0];
   assign bus.req1_ready  = accept && grant_q[1];
   assign bus.tx_start    = tx_start_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.grant       = grant_q;
   assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: packets, alternation, blocking, timeout,
// tx_ready stall and asynchronous reset. Sampling happens 2 ns after posedge.
module tb_uart_tx_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   int   bad;

   uart_tx_arbiter_if bus ();

   uart_tx_arbiter #(
      .GAP_CYCLES    (16),
      .TIMEOUT_CYCLES(50)
   ) dut (
      .CLK100MHZ(clk),
      .reset    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // n ticks in total; tx_done is seen by the DUT on the last one.
   task automatic finish_byte(input int n);
      repeat (n - 1) tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b0;
      bus.req0_data  = 8'h55;
      bus.req1_data  = 8'h00;
      bus.req0_last  = 1'b0;
      bus.req1_last  = 1'b0;
      bus.tx_ready   = 1'b1;
      bus.tx_done    = 1'b0;
      tick();
      tick();
      check("rst_grant",   32'(bus.grant), 32'h0);
      check("rst_start",   32'(bus.tx_start), 32'h0);
      check("rst_data",    32'(bus.tx_data), 32'h0);
      check("rst_ready0",  32'(bus.req0_ready), 32'h0);
      check("rst_timeout", 32'(bus.timeout_err), 32'h0);

      // Single req0 packet 55, AA(last)
      rst = 1'b0;
      tick();
      check("p1_grant",  32'(bus.grant), 32'h1);
      check("p1_ready0", 32'(bus.req0_ready), 32'h1);
      check("p1_nostart", 32'(bus.tx_start), 32'h0);
      tick();
      check("p1_start0", 32'(bus.tx_start), 32'h1);
      check("p1_data0",  32'(bus.tx_data), 32'h55);
      bus.req0_data = 8'hAA;
      bus.req0_last = 1'b1;
      tick();
      check("p1_pulse",   32'(bus.tx_start), 32'h0);
      check("p1_wait_rdy", 32'(bus.req0_ready), 32'h0);
      finish_byte(9);
      check("p1_grant_mid", 32'(bus.grant), 32'h1);
      check("p1_data_hold", 32'(bus.tx_data), 32'h55);
      check("p1_ready1",    32'(bus.req0_ready), 32'h1);
      tick();
      check("p1_start1", 32'(bus.tx_start), 32'h1);
      check("p1_data1",  32'(bus.tx_data), 32'hAA);
      bus.req0_valid = 1'b0;
      bus.req0_last  = 1'b0;
      finish_byte(10);
      check("p1_gap_grant", 32'(bus.grant), 32'h0);
      check("p1_gap_data",  32'(bus.tx_data), 32'hAA);
      repeat (16) tick();

      // Reset restores req0 priority; alternate three 1-byte packets
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_data = 8'h11; bus.req0_last = 1'b1;
      bus.req1_valid = 1'b1; bus.req1_data = 8'h22; bus.req1_last = 1'b1;
      tick();
      check("rr_first_grant", 32'(bus.grant), 32'h1);
      check("rr_first_rdy0",  32'(bus.req0_ready), 32'h1);
      check("rr_first_rdy1",  32'(bus.req1_ready), 32'h0);
      tick();
      check("rr_first_data", 32'(bus.tx_data), 32'h11);
      bus.req0_data = 8'h33;
      finish_byte(3);
      check("rr_gap1", 32'(bus.grant), 32'h0);
      repeat (16) tick();
      check("rr_idle1", 32'(bus.grant), 32'h0);
      tick();
      check("rr_second_grant", 32'(bus.grant), 32'h2);
      check("rr_second_rdy1",  32'(bus.req1_ready), 32'h1);
      check("rr_second_rdy0",  32'(bus.req0_ready), 32'h0);
      tick();
      check("rr_second_data", 32'(bus.tx_data), 32'h22);
      bus.req1_data = 8'h44;
      finish_byte(3);
      repeat (16) tick();
      tick();
      check("rr_third_grant", 32'(bus.grant), 32'h1);
      tick();
      check("rr_third_data", 32'(bus.tx_data), 32'h33);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      finish_byte(3);
      repeat (16) tick();

      // req1 blocked for the whole of req0's 3-byte packet plus gap
      bus.req0_valid = 1'b1; bus.req0_data = 8'hA1; bus.req0_last = 1'b0;
      tick();
      check("blk_grant", 32'(bus.grant), 32'h1);
      tick();
      check("blk_data1", 32'(bus.tx_data), 32'hA1);
      bus.req0_data  = 8'hA2;
      bus.req1_valid = 1'b1; bus.req1_data = 8'hB1; bus.req1_last = 1'b1;
      finish_byte(4);
      check("blk_rdy1_mid", 32'(bus.req1_ready), 32'h0);
      check("blk_grant_mid", 32'(bus.grant), 32'h1);
      tick();
      check("blk_data2", 32'(bus.tx_data), 32'hA2);
      bus.req0_data = 8'hA3;
      bus.req0_last = 1'b1;
      finish_byte(4);
      tick();
      check("blk_data3", 32'(bus.tx_data), 32'hA3);
      bus.req0_valid = 1'b0;
      bus.req0_last  = 1'b0;
      finish_byte(4);
      check("blk_gap_grant", 32'(bus.grant), 32'h0);
      bad = 0;
      repeat (16) begin
         tick();
         if (bus.req1_ready !== 1'b0 || bus.grant !== 2'b00) bad++;
      end
      check("blk_gap_hold", 32'(bad), 32'h0);
      tick();
      check("blk_req1_grant", 32'(bus.grant), 32'h2);
      check("blk_req1_rdy",   32'(bus.req1_ready), 32'h1);
      tick();
      check("blk_req1_data", 32'(bus.tx_data), 32'hB1);
      bus.req1_valid = 1'b0;
      finish_byte(3);
      repeat (16) tick();

      // req0 stalls mid-packet; abort after 50 silent LOAD cycles
      bus.req0_valid = 1'b1; bus.req0_data = 8'hC1; bus.req0_last = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_data = 8'hD1; bus.req1_last = 1'b1;
      tick();
      check("to_grant", 32'(bus.grant), 32'h1);
      tick();
      check("to_data", 32'(bus.tx_data), 32'hC1);
      bus.req0_valid = 1'b0;
      finish_byte(2);
      check("to_load_grant", 32'(bus.grant), 32'h1);
      bad = 0;
      repeat (49) begin
         tick();
         if (bus.timeout_err !== 1'b0) bad++;
      end
      check("to_no_early", 32'(bad), 32'h0);
      tick();
      check("to_pulse", 32'(bus.timeout_err), 32'h1);
      check("to_grant_drop", 32'(bus.grant), 32'h0);
      bus.req0_valid = 1'b1; bus.req0_data = 8'hC2; bus.req0_last = 1'b1;
      tick();
      check("to_pulse_end", 32'(bus.timeout_err), 32'h0);
      repeat (15) tick();
      check("to_gap_end", 32'(bus.grant), 32'h0);
      tick();
      check("to_req1_next", 32'(bus.grant), 32'h2);
      tick();
      check("to_req1_data", 32'(bus.tx_data), 32'hD1);
      bus.req1_valid = 1'b0;
      bus.tx_ready   = 1'b0;
      bus.req0_data  = 8'hE1;
      finish_byte(2);
      repeat (16) tick();

      // tx_ready low holds off acceptance without aging the requester
      tick();
      check("st_grant", 32'(bus.grant), 32'h1);
      check("st_ready", 32'(bus.req0_ready), 32'h0);
      bad = 0;
      repeat (60) begin
         tick();
         if (bus.req0_ready !== 1'b0 || bus.timeout_err !== 1'b0 || bus.tx_start !== 1'b0) bad++;
      end
      check("st_hold", 32'(bad), 32'h0);
      bus.tx_ready = 1'b1;
      #1;
      check("st_accept_rdy", 32'(bus.req0_ready), 32'h1);
      tick();
      check("st_start", 32'(bus.tx_start), 32'h1);
      check("st_data",  32'(bus.tx_data), 32'hE1);

      // Asynchronous reset in WAIT, then a stray tx_done
      bus.req0_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("ar_grant",   32'(bus.grant), 32'h0);
      check("ar_data",    32'(bus.tx_data), 32'h0);
      check("ar_start",   32'(bus.tx_start), 32'h0);
      check("ar_timeout", 32'(bus.timeout_err), 32'h0);
      tick();
      rst = 1'b0;
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      check("ar_stray_start", 32'(bus.tx_start), 32'h0);
      check("ar_stray_grant", 32'(bus.grant), 32'h0);
      tick();
      check("ar_stray_start2", 32'(bus.tx_start), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
